evenodd_window_classifier: RTL and testbench

- Streaming successor to the team's combinational even/odd detector.
- Classifies each accepted WIDTH-bit sample as even or odd and presents the result on a registered valid/ready output stage.
- Counts even and odd samples over a window of WINDOW accepted samples. At window end it holds a count report until it is acknowledged.
- Sits between a sample producer and downstream statistics logic.

---
 rtl/evenodd_window_classifier_if.sv | 39 +++
 rtl/evenodd_window_classifier.sv | 156 +++++++++++++++
 tb/tb_evenodd_window_classifier.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/evenodd_window_classifier_if.sv
// Stream, per-sample result and window report signals of evenodd_window_classifier.
// EVENODD_WIN_MAJORITY_EN adds the win_major_odd report bit.
interface evenodd_window_classifier_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic             even;
  logic             odd;
  logic             win_valid;
  logic             win_ack;
  logic [CNT_W-1:0] win_even_cnt;
  logic [CNT_W-1:0] win_odd_cnt;
`ifdef EVENODD_WIN_MAJORITY_EN
  logic             win_major_odd;

  modport slave (
    input  in_valid, x, out_ready, win_ack,
    output in_ready, out_valid, even, odd, win_valid, win_even_cnt, win_odd_cnt, win_major_odd
  );
  modport master (
    output in_valid, x, out_ready, win_ack,
    input  in_ready, out_valid, even, odd, win_valid, win_even_cnt, win_odd_cnt, win_major_odd
  );
`else
  modport slave (
    input  in_valid, x, out_ready, win_ack,
    output in_ready, out_valid, even, odd, win_valid, win_even_cnt, win_odd_cnt
  );
  modport master (
    output in_valid, x, out_ready, win_ack,
    input  in_ready, out_valid, even, odd, win_valid, win_even_cnt, win_odd_cnt
  );
`endif
endinterface

// File: rtl/evenodd_window_classifier.sv
// Streaming even/odd classifier with registered result stage and windowed count report.
// Optional majority report bit under EVENODD_WIN_MAJORITY_EN.
module evenodd_window_classifier #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic mode,
  evenodd_window_classifier_if.slave bus
);

  localparam int unsigned LAST = WINDOW - 1;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             even_q, even_d;
  logic             odd_q, odd_d;
  logic             win_valid_q, win_valid_d;
  logic [CNT_W-1:0] win_even_q, win_even_d;
  logic [CNT_W-1:0] win_odd_q, win_odd_d;
  logic [CNT_W-1:0] even_acc_q, even_acc_d;
  logic [CNT_W-1:0] odd_acc_q, odd_acc_d;
  logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
`ifdef EVENODD_WIN_MAJORITY_EN
  logic             win_major_q, win_major_d;
`endif

  logic [WIDTH-1:0] x_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             odd_c;
  logic [CNT_W-1:0] even_fin_c;
  logic [CNT_W-1:0] odd_fin_c;

  assign x_c        = bus.x;
  assign in_ready_c = (state_q == ACCUM) && !clear && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign odd_c      = mode ? ^x_c : x_c[0];
  // Counts including the sample being accepted this cycle
  assign even_fin_c = odd_c ? even_acc_q : even_acc_q + CNT_W'(1);
  assign odd_fin_c  = odd_c ? odd_acc_q + CNT_W'(1) : odd_acc_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    even_d      = even_q;
    odd_d       = odd_q;
    win_valid_d = win_valid_q;
    win_even_d  = win_even_q;
    win_odd_d   = win_odd_q;
    even_acc_d  = even_acc_q;
    odd_acc_d   = odd_acc_q;
    samp_cnt_d  = samp_cnt_q;
`ifdef EVENODD_WIN_MAJORITY_EN
    win_major_d = win_major_q;
`endif

    // Per-sample result stage; even/odd hold after drain
    if (accept_c) begin
      out_valid_d = 1'b1;
      odd_d       = odd_c;
      even_d      = !odd_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ACCUM: begin
        if (clear) begin
          even_acc_d = '0;
          odd_acc_d  = '0;
          samp_cnt_d = '0;
        end else if (accept_c) begin
          if (samp_cnt_q == CNT_W'(LAST)) begin
            win_even_d  = even_fin_c;
            win_odd_d   = odd_fin_c;
            win_valid_d = 1'b1;
`ifdef EVENODD_WIN_MAJORITY_EN
            win_major_d = (odd_fin_c > even_fin_c);
`endif
            even_acc_d  = '0;
            odd_acc_d   = '0;
            samp_cnt_d  = '0;
            state_d     = REPORT;
          end else begin
            even_acc_d = even_fin_c;
            odd_acc_d  = odd_fin_c;
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
          end
        end
      end
      REPORT: begin
        if (clear || bus.win_ack) begin
          win_valid_d = 1'b0;
          even_acc_d  = '0;
          odd_acc_d   = '0;
          samp_cnt_d  = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      out_valid_q <= 1'b0;
      even_q      <= 1'b0;
      odd_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_even_q  <= '0;
      win_odd_q   <= '0;
      even_acc_q  <= '0;
      odd_acc_q   <= '0;
      samp_cnt_q  <= '0;
`ifdef EVENODD_WIN_MAJORITY_EN
      win_major_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      win_valid_q <= win_valid_d;
      win_even_q  <= win_even_d;
      win_odd_q   <= win_odd_d;
      even_acc_q  <= even_acc_d;
      odd_acc_q   <= odd_acc_d;
      samp_cnt_q  <= samp_cnt_d;
`ifdef EVENODD_WIN_MAJORITY_EN
      win_major_q <= win_major_d;
`endif
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.even         = even_q;
  assign bus.odd          = odd_q;
  assign bus.win_valid    = win_valid_q;
  assign bus.win_even_cnt = win_even_q;
  assign bus.win_odd_cnt  = win_odd_q;
`ifdef EVENODD_WIN_MAJORITY_EN
  assign bus.win_major_odd = win_major_q;
`endif

endmodule

// File: tb/tb_evenodd_window_classifier.sv
// Directed plus randomized bench for evenodd_window_classifier (WIDTH=4, WINDOW=4).
// EVENODD_WIN_MAJORITY_EN also checks win_major_odd.
module tb_evenodd_window_classifier;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned WINDOW = 4;
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

  logic clk;
  logic rst_n;
  logic clear;
  logic mode;

  evenodd_window_classifier_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  evenodd_window_classifier #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .mode  (mode),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: result register contents plus the odd flags of the current window
  bit m_out_valid, m_even, m_odd, m_win_valid, m_major;
  int m_win_even, m_win_odd;
  bit win_samples[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] xx, input logic md, input logic ordy,
                      input logic ack, input logic clr, input logic rstn);
    bit exp_ready, acc, ob;
    int ones;
    @(negedge clk);
    rst_n = rstn; clear = clr; mode = md;
    bus.in_valid = v; bus.x = xx; bus.out_ready = ordy; bus.win_ack = ack;
    exp_ready = !m_win_valid && !clr && (!m_out_valid || ordy);
    #1;
    if (rstn) check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rstn) begin
      m_out_valid = 0; m_even = 0; m_odd = 0; m_win_valid = 0; m_major = 0;
      m_win_even = 0; m_win_odd = 0; win_samples.delete();
    end else begin
      acc = v && exp_ready;
      ob  = md ? ^xx : xx[0];
      if (acc) begin
        m_out_valid = 1; m_odd = ob; m_even = !ob;
      end else if (ordy) begin
        m_out_valid = 0;
      end
      if (m_win_valid) begin
        if (clr || ack) m_win_valid = 0;
      end else if (clr) begin
        win_samples.delete();
      end else if (acc) begin
        win_samples.push_back(ob);
        if (win_samples.size() == WINDOW) begin
          ones = 0;
          foreach (win_samples[i]) ones += int'(win_samples[i]);
          m_win_odd   = ones;
          m_win_even  = WINDOW - ones;
          m_major     = (m_win_odd > m_win_even);
          m_win_valid = 1;
          win_samples.delete();
        end
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
    check("even", 32'(bus.even), 32'(m_even));
    check("odd", 32'(bus.odd), 32'(m_odd));
    check("win_valid", 32'(bus.win_valid), 32'(m_win_valid));
    check("win_even_cnt", 32'(bus.win_even_cnt), 32'(m_win_even));
    check("win_odd_cnt", 32'(bus.win_odd_cnt), 32'(m_win_odd));
`ifdef EVENODD_WIN_MAJORITY_EN
    check("win_major_odd", 32'(bus.win_major_odd), 32'(m_major));
`endif
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'h0, 1'b0, ordy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input logic [3:0] xx, input logic md, input logic ordy);
    step(1'b1, xx, md, ordy, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0;
    bus.in_valid = 1'b0; bus.x = '0; bus.out_ready = 1'b0; bus.win_ack = 1'b0;

    // Reset then idle
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Mode 0 then mode 1; the 4th sample closes a 2/2 tie window
    send(4'h3, 1'b0, 1'b1);
    check("m0_x3_odd", 32'(bus.odd), 32'd1);
    send(4'h6, 1'b0, 1'b1);
    check("m0_x6_even", 32'(bus.even), 32'd1);
    send(4'h3, 1'b1, 1'b1);
    check("m1_x3_even", 32'(bus.even), 32'd1);
    send(4'h7, 1'b1, 1'b1);
    check("m1_x7_odd", 32'(bus.odd), 32'd1);
    check("tie_win_valid", 32'(bus.win_valid), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Window report x=1,2,3,5, held 5 cycles with samples offered
    send(4'h1, 1'b0, 1'b1);
    send(4'h2, 1'b0, 1'b1);
    send(4'h3, 1'b0, 1'b1);
    send(4'h5, 1'b0, 1'b1);
    check("rep_even_cnt", 32'(bus.win_even_cnt), 32'd1);
    check("rep_odd_cnt", 32'(bus.win_odd_cnt), 32'd3);
`ifdef EVENODD_WIN_MAJORITY_EN
    check("rep_major", 32'(bus.win_major_odd), 32'd1);
`endif
    for (int i = 0; i < 5; i++) send(4'h9, 1'b0, 1'b1);
    check("rep_held", 32'(bus.win_valid), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ack_clears", 32'(bus.win_valid), 32'd0);
    idle(1'b1);
    check("ack_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure
    send(4'h1, 1'b0, 1'b0);
    send(4'h2, 1'b0, 1'b0);
    check("bp_hold_odd", 32'(bus.odd), 32'd1);
    send(4'h2, 1'b0, 1'b1);
    check("bp_even", 32'(bus.even), 32'd1);

    // clear mid-window, then a full fresh window is required
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(4'(i + 1), 1'b0, 1'b1);
    step(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(4'(i + 4), 1'b0, 1'b1);
    check("clr_no_report", 32'(bus.win_valid), 32'd0);
    send(4'h8, 1'b0, 1'b1);
    check("clr_report", 32'(bus.win_valid), 32'd1);

    // Reset during report
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_win_valid", 32'(bus.win_valid), 32'd0);
    check("rst_counts", 32'({bus.win_even_cnt, bus.win_odd_cnt}), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom()), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
